osc_event_generator: RTL and testbench
======================================

Name: osc_event_generator

Overview:
- Producer side of the oscilloscope menu event interface.
- Turns raw board buttons and PS/2 keyboard lines into single-cycle, edge-detected navigation events: ev_up_pe, ev_down_pe, ev_ok_pe, ev_left_pe, ev_right_pe.
- Sits between the top-level pins (btns, kd, kc) and menu_osciloscopio_state in osciloscopio, on the DCM-generated system clock.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable samples required before a button level is accepted (10 ms at 50 MHz).
- PS2_TIMEOUT_CYCLES, 50000, maximum clk cycles between kc falling edges inside a frame before the frame is aborted.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- btns  input  4  raw buttons: [0] up, [1] down, [2] ok, [3] right.
- kd  input  1  PS/2 data, asynchronous.
- kc  input  1  PS/2 clock, asynchronous.
- ev_up_pe  output  1  one-cycle up event.
- ev_down_pe  output  1  one-cycle down event.
- ev_ok_pe  output  1  one-cycle ok event.
- ev_left_pe  output  1  one-cycle left event (keyboard only).
- ev_right_pe  output  1  one-cycle right event.
- kb_err  output  1  one-cycle pulse on a PS/2 parity or stop-bit error.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high, sampled on the rising edge of clk. During reset and on the first cycle after it, all outputs are 0. Reset clears the synchronizers, debounce counters, debounced levels, PS/2 FSM, shift register and decoder flags. A reset in mid-frame discards the partial frame.
- Buttons:
  - Each bit passes through a 2-FF synchronizer.
  - Per-bit counter: it resets to 0 when the synchronized value equals the debounced level. Otherwise it increments, and when it reaches DEBOUNCE_CYCLES-1 the debounced level flips and the counter clears.
  - Debounced level 0->1 produces a one-cycle pulse on the next cycle. Release (1->0) produces no event.
  - Holding a button produces exactly one pulse.
- PS/2 receiver:
  - kc and kd each pass through a 2-FF synchronizer. A falling edge is when the previous synchronized kc is 1 and the current one is 0. kd is sampled on that edge.
  - FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a falling edge with kd=0 (start bit), go to DATA with bit count 0. If kd=1, stay in IDLE.
  - DATA: shift 8 bits, LSB first. After the 8th bit, go to PARITY.
  - PARITY: capture the bit, then go to STOP.
  - STOP: the frame is valid when kd=1 and the 8 data bits plus the parity bit contain an odd number of ones. A valid frame raises byte_rdy for one cycle. Otherwise kb_err pulses for one cycle and the byte is dropped. Either way, return to IDLE.
  - Timeout: in any state other than IDLE, if PS2_TIMEOUT_CYCLES pass without a falling edge, return to IDLE silently. No kb_err.
- Scan-code decoder:
  - Flags: ext (set by byte E0), brk (set by byte F0). Both persist until the next non-prefix byte.
  - On a non-prefix byte with brk=1: no event; clear ext and brk.
  - On a non-prefix byte with brk=0, map as follows, then clear both flags:
    - ext & 75 -> up.
    - ext & 72 -> down.
    - ext & 6B -> left.
    - ext & 74 -> right.
    - 5A (with or without ext) -> ok.
    - Any other code -> no event.
  - Typematic repeats of a make code generate repeated events; this is intended auto-repeat.
- Latency and merging:
  - Keyboard events: the ev_*_pe pulse is asserted exactly 2 clk cycles after the synchronized kc falling edge that samples the stop bit (byte_rdy registered, then the event registered).
  - Button events: 1 cycle after the debounced rising edge.
  - Each output is the registered OR of its button source and keyboard source. A button and a key for the same event in the same cycle give a single one-cycle pulse. Distinct events may assert in the same cycle.
  - No output is ever high for two consecutive cycles from a single source event.

Test Plan:
- Reset, then hold btns[0]=1 with 3 short glitches (<DEBOUNCE_CYCLES, with DEBOUNCE_CYCLES=16 in the bench) before a stable press -> exactly one ev_up_pe pulse, 1 cycle after the debounced rise. Release -> no pulse.
- Keyboard frames E0,75 then E0,F0,75 -> one ev_up_pe pulse 2 cycles after the stop bit of 75. The break sequence produces nothing.
- Frame 5A, then 5A again (typematic), then E0,5A -> three ev_ok_pe pulses. Frame 1C -> no event.
- Frame with a corrupted parity bit on byte 72 after E0 -> kb_err one pulse, no ev_down_pe. A following E0,72 -> ev_down_pe.
- Stop kc after 4 data bits for more than PS2_TIMEOUT_CYCLES, then send a full E0,6B -> no kb_err; ev_left_pe asserts once.
- btns[3] debounced rise in the same cycle as the keyboard E0,74 event -> single one-cycle ev_right_pe. Assert rst mid-frame -> all outputs 0 and the partial frame discarded.

Source files
------------

// File: rtl/osc_event_generator.sv
// rtl/osc_event_generator.sv - menu navigation events from debounced buttons and PS/2 scan codes
module osc_event_generator #(
  parameter int DEBOUNCE_CYCLES    = 500000,
  parameter int PS2_TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btns,
  input  logic       kd,
  input  logic       kc,
  output logic       ev_up_pe,
  output logic       ev_down_pe,
  output logic       ev_ok_pe,
  output logic       ev_left_pe,
  output logic       ev_right_pe,
  output logic       kb_err
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W = $clog2(PS2_TIMEOUT_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(PS2_TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_OK    = 8'h5A;

  // Button path: synchronize, debounce, detect debounced rising edge
  logic [3:0]      r_btn_s1;
  logic [3:0]      r_btn_s2;
  logic [3:0]      r_btn_db;
  logic [3:0]      r_btn_db_d;
  logic [DB_W-1:0] r_db_cnt [4];
  logic [3:0]      w_btn_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_s1   <= '0;
      r_btn_s2   <= '0;
      r_btn_db   <= '0;
      r_btn_db_d <= '0;
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
    end else begin
      r_btn_s1   <= btns;
      r_btn_s2   <= r_btn_s1;
      r_btn_db_d <= r_btn_db;
      for (int i = 0; i < 4; i++) begin
        if (r_btn_s2[i] == r_btn_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_btn_db[i] <= ~r_btn_db[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign w_btn_rise = r_btn_db & ~r_btn_db_d;

  // PS/2 line synchronizers and kc falling-edge detect
  logic r_kc_s1;
  logic r_kc_s2;
  logic r_kc_prev;
  logic r_kd_s1;
  logic r_kd_s2;
  logic w_kc_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_kc_s1   <= 1'b0;
      r_kc_s2   <= 1'b0;
      r_kc_prev <= 1'b0;
      r_kd_s1   <= 1'b0;
      r_kd_s2   <= 1'b0;
    end else begin
      r_kc_s1   <= kc;
      r_kc_s2   <= r_kc_s1;
      r_kc_prev <= r_kc_s2;
      r_kd_s1   <= kd;
      r_kd_s2   <= r_kd_s1;
    end
  end

  assign w_kc_fall = r_kc_prev & ~r_kc_s2;

  // Frame receiver; the timeout abandons a stalled frame without flagging an error
  logic [1:0]      r_state;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_parity;
  logic [7:0]      r_byte;
  logic            r_byte_rdy;
  logic            r_kb_err;
  logic [TO_W-1:0] r_to_cnt;
  logic            w_timeout;

  assign w_timeout = (r_state != S_IDLE) && !w_kc_fall && (r_to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_byte     <= '0;
      r_byte_rdy <= 1'b0;
      r_kb_err   <= 1'b0;
      r_to_cnt   <= '0;
    end else begin
      r_byte_rdy <= 1'b0;
      r_kb_err   <= 1'b0;
      if (r_state == S_IDLE || w_kc_fall) r_to_cnt <= '0;
      else                                r_to_cnt <= r_to_cnt + TO_W'(1);

      if (w_timeout) begin
        r_state <= S_IDLE;
      end else if (w_kc_fall) begin
        case (r_state)
          S_IDLE: begin
            if (!r_kd_s2) begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
            end
          end
          S_DATA: begin
            r_shift   <= {r_kd_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
          end
          S_PARITY: begin
            r_parity <= r_kd_s2;
            r_state  <= S_STOP;
          end
          default: begin
            if (r_kd_s2 && (^{r_shift, r_parity})) begin
              r_byte     <= r_shift;
              r_byte_rdy <= 1'b1;
            end else begin
              r_kb_err <= 1'b1;
            end
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Scan-code decoder: E0/F0 prefixes qualify the next non-prefix byte
  logic r_ext;
  logic r_brk;
  logic w_prefix;
  logic w_make;
  logic w_kb_up;
  logic w_kb_down;
  logic w_kb_ok;
  logic w_kb_left;
  logic w_kb_right;

  assign w_prefix = (r_byte == SC_EXT) || (r_byte == SC_BRK);
  assign w_make   = r_byte_rdy && !w_prefix && !r_brk;

  always_comb begin
    w_kb_up    = 1'b0;
    w_kb_down  = 1'b0;
    w_kb_ok    = 1'b0;
    w_kb_left  = 1'b0;
    w_kb_right = 1'b0;
    if (w_make) begin
      w_kb_up    = r_ext && (r_byte == SC_UP);
      w_kb_down  = r_ext && (r_byte == SC_DOWN);
      w_kb_left  = r_ext && (r_byte == SC_LEFT);
      w_kb_right = r_ext && (r_byte == SC_RIGHT);
      w_kb_ok    = (r_byte == SC_OK);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (r_byte_rdy) begin
      if (r_byte == SC_EXT) begin
        r_ext <= 1'b1;
      end else if (r_byte == SC_BRK) begin
        r_brk <= 1'b1;
      end else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  end

  // Merged, registered event outputs
  logic r_ev_up;
  logic r_ev_down;
  logic r_ev_ok;
  logic r_ev_left;
  logic r_ev_right;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ev_up    <= 1'b0;
      r_ev_down  <= 1'b0;
      r_ev_ok    <= 1'b0;
      r_ev_left  <= 1'b0;
      r_ev_right <= 1'b0;
    end else begin
      r_ev_up    <= w_btn_rise[0] | w_kb_up;
      r_ev_down  <= w_btn_rise[1] | w_kb_down;
      r_ev_ok    <= w_btn_rise[2] | w_kb_ok;
      r_ev_left  <= w_kb_left;
      r_ev_right <= w_btn_rise[3] | w_kb_right;
    end
  end

  assign ev_up_pe    = r_ev_up;
  assign ev_down_pe  = r_ev_down;
  assign ev_ok_pe    = r_ev_ok;
  assign ev_left_pe  = r_ev_left;
  assign ev_right_pe = r_ev_right;
  assign kb_err      = r_kb_err;

endmodule

// File: tb/tb_osc_event_generator.sv
// tb/tb_osc_event_generator.sv - scoreboard bench for osc_event_generator
module tb_osc_event_generator;

  localparam int DB = 16;
  localparam int TO = 100;

  // mask bit order: {kb_err, right, left, ok, down, up}
  localparam logic [5:0] M_UP    = 6'b000001;
  localparam logic [5:0] M_DOWN  = 6'b000010;
  localparam logic [5:0] M_OK    = 6'b000100;
  localparam logic [5:0] M_LEFT  = 6'b001000;
  localparam logic [5:0] M_RIGHT = 6'b010000;
  localparam logic [5:0] M_ERR   = 6'b100000;

  typedef struct {
    int         cyc;
    logic [5:0] mask;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btns;
  logic       kd;
  logic       kc;
  logic       ev_up_pe, ev_down_pe, ev_ok_pe, ev_left_pe, ev_right_pe, kb_err;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  osc_event_generator #(
    .DEBOUNCE_CYCLES(DB),
    .PS2_TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .btns(btns), .kd(kd), .kc(kc),
    .ev_up_pe(ev_up_pe), .ev_down_pe(ev_down_pe), .ev_ok_pe(ev_ok_pe),
    .ev_left_pe(ev_left_pe), .ev_right_pe(ev_right_pe), .kb_err(kb_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [5:0] outs;
  assign outs = {kb_err, ev_right_pe, ev_left_pe, ev_ok_pe, ev_down_pe, ev_up_pe};

  // Monitor: every nonzero output cycle must match the head of the scoreboard
  always @(negedge clk) begin
    if (outs != 6'b0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL event: unexpected outputs %b at cycle %0d, required none", outs, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.cyc != cyc || e.mask != outs) begin
          errors++;
          $display("FAIL event: cycle %0d outputs %b, required cycle %0d outputs %b",
                   cyc, outs, e.cyc, e.mask);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [5:0] m);
    exp_t e;
    e.cyc  = c;
    e.mask = m;
    sb.push_back(e);
  endtask

  task automatic check_zero(input string name);
    @(negedge clk);
    checks++;
    if (outs != 6'b0) begin
      errors++;
      $display("FAIL %s: outputs %b, required 000000", name, outs);
    end
    tick(1);
  endtask

  task automatic send_bit(input logic b);
    kd = b;
    tick(4);
    kc = 1'b0;
    tick(4);
    kc = 1'b1;
  endtask

  // Stop-bit kc fall after edge T: kb_err visible at T+3, events at T+4
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic [5:0] m);
    logic p;
    p = ~(^b) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    kd = 1'b1;
    tick(4);
    kc = 1'b0;
    if (m != 6'b0) push(cyc + (m[5] ? 3 : 4), m);
    tick(4);
    kc = 1'b1;
    tick(8);
  endtask

  task automatic send_partial(input int nbits);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(i[0]);
    kd = 1'b1;
  endtask

  initial begin
    rst = 1'b1; btns = 4'b0; kd = 1'b1; kc = 1'b1;
    tick(1);
    check_zero("reset_a");
    check_zero("reset_b");
    rst = 1'b0;
    check_zero("post_reset");

    // Up button: three short glitches, then a stable press; latency D+3 edges
    for (int g = 0; g < 3; g++) begin
      btns[0] = 1'b1; tick(5);
      btns[0] = 1'b0; tick(5);
    end
    btns[0] = 1'b1;
    push(cyc + DB + 3, M_UP);
    tick(60);
    btns[0] = 1'b0;
    tick(60);

    // Extended up make, then its break sequence
    send_frame(8'hE0, 1'b0, 6'b0);
    send_frame(8'h75, 1'b0, M_UP);
    send_frame(8'hE0, 1'b0, 6'b0);
    send_frame(8'hF0, 1'b0, 6'b0);
    send_frame(8'h75, 1'b0, 6'b0);

    // ok: plain, typematic repeat, extended; 1C maps to nothing
    send_frame(8'h5A, 1'b0, M_OK);
    send_frame(8'h5A, 1'b0, M_OK);
    send_frame(8'hE0, 1'b0, 6'b0);
    send_frame(8'h5A, 1'b0, M_OK);
    send_frame(8'h1C, 1'b0, 6'b0);

    // Corrupted parity on 72 after E0, then a clean E0,72
    send_frame(8'hE0, 1'b0, 6'b0);
    send_frame(8'h72, 1'b1, M_ERR);
    send_frame(8'hE0, 1'b0, 6'b0);
    send_frame(8'h72, 1'b0, M_DOWN);

    // Stalled frame after 4 data bits, then E0,6B
    send_partial(4);
    tick(TO + 50);
    send_frame(8'hE0, 1'b0, 6'b0);
    send_frame(8'h6B, 1'b0, M_LEFT);

    // Right button rise lands on the same cycle as the E0,74 keyboard event (S+88)
    send_frame(8'hE0, 1'b0, 6'b0);
    fork
      send_frame(8'h74, 1'b0, 6'b0);
      begin
        tick(85 - DB);
        btns[3] = 1'b1;
        push(cyc + DB + 3, M_RIGHT);
      end
    join
    tick(40);
    btns[3] = 1'b0;
    tick(60);

    // Reset in mid-frame discards the partial frame
    send_partial(5);
    rst = 1'b1;
    check_zero("mid_reset_a");
    check_zero("mid_reset_b");
    check_zero("mid_reset_c");
    rst = 1'b0;
    check_zero("mid_post_reset");
    tick(4);
    send_frame(8'h5A, 1'b0, M_OK);
    tick(20);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected events never seen, required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
